// File: rtl/exmem_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: M-bundle field indices,
// default payload layout and the skid buffer state encoding.
package exmem_pkg;

  localparam int EXMEM_DATA_W   = 32;
  localparam int EXMEM_REG_W    = 5;
  localparam int EXMEM_WB_W     = 2;
  localparam int EXMEM_MEM_OP_W = 2;
  localparam int EXMEM_CNT_W    = 16;
  localparam int EXMEM_M_W      = 2*EXMEM_MEM_OP_W + 1;

  // M bundle: {Branch, MemWrite[MEM_OP_W], MemRead[MEM_OP_W]}
  localparam int M_BRANCH_IDX = 2*EXMEM_MEM_OP_W;
  localparam int M_WRITE_HI   = 2*EXMEM_MEM_OP_W - 1;
  localparam int M_WRITE_LO   = EXMEM_MEM_OP_W;
  localparam int M_READ_HI    = EXMEM_MEM_OP_W - 1;
  localparam int M_READ_LO    = 0;

  typedef struct packed {
    logic [EXMEM_WB_W-1:0]   wb;
    logic [EXMEM_M_W-1:0]    m;
    logic [EXMEM_DATA_W-1:0] branch_add;
    logic [EXMEM_DATA_W-1:0] alu_result;
    logic                    alu_zero;
    logic [EXMEM_REG_W-1:0]  write_reg;
    logic [EXMEM_DATA_W-1:0] read_data2;
  } exmem_payload_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_FULL1 = 2'd1,
    SKID_FULL2 = 2'd2
  } skid_state_t;

  function automatic logic [1:0] popcount3(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/exmem_skid_buf.sv
// Generic 2-entry skid buffer (output register + one skid entry) with flush
// and a registered in_ready; used by the stage when EXMEM_SKID_EN is defined.
module exmem_skid_buf
  import exmem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         skid_valid
);

  skid_state_t  state_reg;
  logic [W-1:0] out_reg;
  logic [W-1:0] skid_reg;
  logic         in_ready_reg;
  logic         accept;
  logic         consume;

  assign accept     = in_valid && in_ready_reg;
  assign consume    = (state_reg != SKID_EMPTY) && out_ready;
  assign in_ready   = in_ready_reg;
  assign out_valid  = (state_reg != SKID_EMPTY);
  assign skid_valid = (state_reg == SKID_FULL2);
  assign out_data   = out_reg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg    <= SKID_EMPTY;
      out_reg      <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else if (flush) begin
      state_reg    <= SKID_EMPTY;
      out_reg      <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        SKID_EMPTY: begin
          if (accept) begin
            out_reg   <= in_data;
            state_reg <= SKID_FULL1;
          end
        end
        SKID_FULL1: begin
          if (accept && consume) begin
            out_reg <= in_data;
          end else if (accept) begin
            skid_reg     <= in_data;
            state_reg    <= SKID_FULL2;
            in_ready_reg <= 1'b0;
          end else if (consume) begin
            out_reg   <= '0;
            state_reg <= SKID_EMPTY;
          end
        end
        SKID_FULL2: begin
          // in_ready is low here, so only the drain path exists
          if (consume) begin
            out_reg      <= skid_reg;
            skid_reg     <= '0;
            state_reg    <= SKID_FULL1;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= SKID_EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX/MEM pipeline register with valid/ready, flush-to-bubble and a saturating
// squashed-beat counter. Define EXMEM_SKID_EN for a 2-entry skid (registered InReady).
module exmem_pipe_stage
  import exmem_pkg::*;
#(
  parameter int DATA_W   = EXMEM_DATA_W,
  parameter int REG_W    = EXMEM_REG_W,
  parameter int WB_W     = EXMEM_WB_W,
  parameter int MEM_OP_W = EXMEM_MEM_OP_W,
  parameter int CNT_W    = EXMEM_CNT_W
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Flush,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [WB_W-1:0]       WBin,
  input  logic [2*MEM_OP_W:0]   Min,
  input  logic [DATA_W-1:0]     BranchAdd,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic                  ALUZero,
  input  logic [REG_W-1:0]      WriteReg,
  input  logic [DATA_W-1:0]     ReadData2,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [WB_W-1:0]       WBout,
  output logic                  MBranch,
  output logic [MEM_OP_W-1:0]   MemWrite,
  output logic [MEM_OP_W-1:0]   MemRead,
  output logic [DATA_W-1:0]     BranchAddout,
  output logic [DATA_W-1:0]     ALUResultout,
  output logic                  ALUZeroOut,
  output logic [REG_W-1:0]      WriteRegout,
  output logic [DATA_W-1:0]     ReadData2out,
  output logic [CNT_W-1:0]      BubbleCnt
);

  localparam int M_W   = 2*MEM_OP_W + 1;
  localparam int PAY_W = WB_W + M_W + 3*DATA_W + 1 + REG_W;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay;
  logic [M_W-1:0]   m_q;
  logic             out_valid;
  logic             skid_valid;

  assign in_pay = {WBin, Min, BranchAdd, ALUResult, ALUZero, WriteReg, ReadData2};
  assign {WBout, m_q, BranchAddout, ALUResultout, ALUZeroOut, WriteRegout, ReadData2out} = out_pay;
  assign MBranch  = m_q[2*MEM_OP_W];
  assign MemWrite = m_q[2*MEM_OP_W-1:MEM_OP_W];
  assign MemRead  = m_q[MEM_OP_W-1:0];
  assign OutValid = out_valid;

`ifdef EXMEM_SKID_EN
  exmem_skid_buf #(.W(PAY_W)) u_skid (
    .Clk       (Clk),
    .Rst       (Rst),
    .flush     (Flush),
    .in_valid  (InValid),
    .in_ready  (InReady),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (OutReady),
    .out_data  (out_pay),
    .skid_valid(skid_valid)
  );
`else
  logic [PAY_W-1:0] out_pay_reg;
  logic             out_valid_reg;

  assign InReady    = OutReady || !out_valid_reg;
  assign out_valid  = out_valid_reg;
  assign out_pay    = out_pay_reg;
  assign skid_valid = 1'b0;

  // Payload is cleared whenever the stage empties so idle control reads 0
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid_reg <= 1'b0;
      out_pay_reg   <= '0;
    end else if (Flush) begin
      out_valid_reg <= 1'b0;
      out_pay_reg   <= '0;
    end else if (InValid && InReady) begin
      out_valid_reg <= 1'b1;
      out_pay_reg   <= in_pay;
    end else if (out_valid_reg && OutReady) begin
      out_valid_reg <= 1'b0;
      out_pay_reg   <= '0;
    end
  end
`endif

  logic [CNT_W-1:0] bubble_cnt_reg;
  logic [1:0]       squash_n;
  logic [CNT_W+1:0] bubble_sum;

  assign squash_n   = Flush ? popcount3(out_valid, skid_valid, InValid) : 2'd0;
  assign bubble_sum = {2'b00, bubble_cnt_reg} + {{CNT_W{1'b0}}, squash_n};
  assign BubbleCnt  = bubble_cnt_reg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bubble_cnt_reg <= '0;
    end else if (bubble_sum > {2'b00, {CNT_W{1'b1}}}) begin
      bubble_cnt_reg <= {CNT_W{1'b1}};
    end else begin
      bubble_cnt_reg <= bubble_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Directed bench for exmem_pipe_stage (CNT_W=4); expectations follow EXMEM_SKID_EN.
module tb_exmem_pipe_stage;

  logic        Clk = 1'b0;
  logic        Rst, Flush, InValid, InReady, ALUZero, OutValid, OutReady;
  logic [1:0]  WBin, WBout, MemWrite, MemRead;
  logic [4:0]  Min, WriteReg, WriteRegout;
  logic [31:0] BranchAdd, ALUResult, ReadData2;
  logic [31:0] BranchAddout, ALUResultout, ReadData2out;
  logic        MBranch, ALUZeroOut;
  logic [3:0]  BubbleCnt;

  int checks = 0;
  int errors = 0;
  int exp_bub = 0;

  always #5 Clk = ~Clk;

  exmem_pipe_stage #(.DATA_W(32), .REG_W(5), .WB_W(2), .MEM_OP_W(2), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .WBin(WBin), .Min(Min), .BranchAdd(BranchAdd), .ALUResult(ALUResult),
    .ALUZero(ALUZero), .WriteReg(WriteReg), .ReadData2(ReadData2),
    .OutValid(OutValid), .OutReady(OutReady), .WBout(WBout), .MBranch(MBranch),
    .MemWrite(MemWrite), .MemRead(MemRead), .BranchAddout(BranchAddout),
    .ALUResultout(ALUResultout), .ALUZeroOut(ALUZeroOut), .WriteRegout(WriteRegout),
    .ReadData2out(ReadData2out), .BubbleCnt(BubbleCnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] alu, input logic [4:0] m, input logic [1:0] wb);
    InValid   = 1'b1;
    ALUResult = alu;
    Min       = m;
    WBin      = wb;
    BranchAdd = alu + 32'h100;
    WriteReg  = alu[4:0];
    ReadData2 = ~alu;
    ALUZero   = (alu == 32'd0);
  endtask

  initial begin
    Rst = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    WBin = '0; Min = '0; BranchAdd = '0; ALUResult = '0; ALUZero = 1'b0;
    WriteReg = '0; ReadData2 = '0;
    repeat (2) step();
    check_eq("rst_valid", 64'(OutValid), 64'd0);
    check_eq("rst_bubble", 64'(BubbleCnt), 64'd0);
    check_eq("rst_inready", 64'(InReady), 64'd1);
    Rst = 1'b0;

    // streaming at full throughput with decode checks
    offer(32'd1, 5'b1_10_01, 2'b11);
    step();
    check_eq("s1_alu", 64'(ALUResultout), 64'd1);
    check_eq("s1_valid", 64'(OutValid), 64'd1);
    check_eq("s1_mbranch", 64'(MBranch), 64'd1);
    check_eq("s1_memwrite", 64'(MemWrite), 64'd2);
    check_eq("s1_memread", 64'(MemRead), 64'd1);
    check_eq("s1_wb", 64'(WBout), 64'd3);
    check_eq("s1_badd", 64'(BranchAddout), 64'h101);
    offer(32'd2, 5'b0_00_00, 2'b01);
    step();
    check_eq("s2_alu", 64'(ALUResultout), 64'd2);
    check_eq("s2_valid", 64'(OutValid), 64'd1);
    check_eq("s2_mbranch", 64'(MBranch), 64'd0);
    offer(32'd3, 5'b0_01_10, 2'b00);
    step();
    check_eq("s3_alu", 64'(ALUResultout), 64'd3);
    check_eq("s3_memwrite", 64'(MemWrite), 64'd1);
    check_eq("s3_memread", 64'(MemRead), 64'd2);
    check_eq("s3_rd2", 64'(ReadData2out), 64'hFFFF_FFFC);
    InValid = 1'b0;
    step();
    check_eq("drain_valid", 64'(OutValid), 64'd0);
    check_eq("drain_memwrite", 64'(MemWrite), 64'd0);
    check_eq("drain_wb", 64'(WBout), 64'd0);

    // asynchronous reset between clock edges
    offer(32'h1234, 5'b1_00_00, 2'b10);
    step();
    check_eq("pre_rst_alu", 64'(ALUResultout), 64'h1234);
    InValid = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(OutValid), 64'd0);
    check_eq("async_rst_alu", 64'(ALUResultout), 64'd0);
    check_eq("async_rst_wb", 64'(WBout), 64'd0);
    check_eq("async_rst_bubble", 64'(BubbleCnt), 64'd0);
    Rst = 1'b0;

    // stall: output held, second beat goes to skid if present
    OutReady = 1'b0;
    offer(32'hA5, 5'b0_10_00, 2'b01);
    step();
    check_eq("st_alu0", 64'(ALUResultout), 64'hA5);
    offer(32'hB6, 5'b0_00_01, 2'b10);
    step();
    check_eq("st_alu1", 64'(ALUResultout), 64'hA5);
    check_eq("st_inready", 64'(InReady), 64'd0);
    step();
    check_eq("st_alu2", 64'(ALUResultout), 64'hA5);
    check_eq("st_wb2", 64'(WBout), 64'd1);
    step();
    check_eq("st_alu3", 64'(ALUResultout), 64'hA5);
    OutReady = 1'b1;
    step();
    InValid = 1'b0;
    check_eq("rel_alu", 64'(ALUResultout), 64'hB6);
    check_eq("rel_valid", 64'(OutValid), 64'd1);
    step();
    check_eq("rel_drain", 64'(OutValid), 64'd0);

    // flush with everything full plus an incoming beat
    OutReady = 1'b0;
    offer(32'hC1, 5'b1_11_11, 2'b11);
    step();
`ifdef EXMEM_SKID_EN
    offer(32'hC2, 5'b1_11_11, 2'b11);
    step();
    exp_bub = 3;
`else
    exp_bub = 2;
`endif
    offer(32'hC3, 5'b1_11_11, 2'b11);
    Flush = 1'b1;
    step();
    Flush = 1'b0; InValid = 1'b0;
    check_eq("fl_valid", 64'(OutValid), 64'd0);
    check_eq("fl_alu", 64'(ALUResultout), 64'd0);
    check_eq("fl_mbranch", 64'(MBranch), 64'd0);
    check_eq("fl_wb", 64'(WBout), 64'd0);
    check_eq("fl_bubble", 64'(BubbleCnt), 64'(exp_bub));
    check_eq("fl_inready", 64'(InReady), 64'd1);
    OutReady = 1'b1;
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check_eq("fl_empty_bubble", 64'(BubbleCnt), 64'(exp_bub));

    // preload counter to 14 with single squashed beats, then saturate
    for (int i = exp_bub; i < 14; i++) begin
      offer(32'(i), 5'b0, 2'b0);
      Flush = 1'b1;
      step();
    end
    Flush = 1'b0; InValid = 1'b0;
    exp_bub = 14;
    check_eq("preload_bubble", 64'(BubbleCnt), 64'(exp_bub));
    OutReady = 1'b0;
    offer(32'hD1, 5'b0, 2'b01);
    step();
    offer(32'hD2, 5'b0, 2'b01);
    Flush = 1'b1;
    step();
    check_eq("sat_bubble", 64'(BubbleCnt), 64'd15);
    check_eq("sat_valid", 64'(OutValid), 64'd0);
    step();
    check_eq("sat_hold", 64'(BubbleCnt), 64'd15);
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
